// File: rtl/pipe_mux_pkg.sv
// Shared constants and state encoding for the registered N:1 select pipe.
package pipe_mux_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_N_IN  = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_n_1.sv
// Combinational N:1 word select; out-of-range selects yield zero and flag err_o.
module mux_n_1
  import pipe_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_IN  = DEF_N_IN,
  localparam int SEL_W = sel_width(N_IN)
) (
  input  logic [N_IN*WIDTH-1:0] in_data_i,
  input  logic [SEL_W-1:0]      sel_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  err_o
);

  always_comb begin
    data_o = '0;
    err_o  = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      if (sel_i == SEL_W'(k)) begin
        data_o = in_data_i[k*WIDTH +: WIDTH];
        err_o  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_mux_reg.sv
// Registered N:1 select with a two-entry main/skid buffer, flush and
// a sticky out-of-range select flag.
module pipe_mux_reg
  import pipe_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_IN  = DEF_N_IN,
  localparam int SEL_W = sel_width(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  flush,
  output logic                  sel_err
);

  state_e           state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             err_q;
  logic [WIDTH-1:0] mux_d;
  logic             mux_err;
  logic             in_xfer;
  logic             out_xfer;

  mux_n_1 #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN)
  ) u_mux (
    .in_data_i (in_data),
    .sel_i     (sel),
    .data_o    (mux_d),
    .err_o     (mux_err)
  );

  // Handshake outputs depend on state only, never on out_ready.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign sel_err   = err_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (in_xfer && mux_err) err_q <= 1'b1;
      if (flush) begin
        state_q <= ST_EMPTY;
      end else begin
        unique case (state_q)
          ST_EMPTY: begin
            if (in_xfer) begin
              main_q  <= mux_d;
              state_q <= ST_ONE;
            end
          end
          ST_ONE: begin
            if (in_xfer && out_xfer) begin
              main_q <= mux_d;
            end else if (in_xfer) begin
              skid_q  <= mux_d;
              state_q <= ST_FULL;
            end else if (out_xfer) begin
              state_q <= ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (out_xfer) begin
              main_q  <= skid_q;
              state_q <= ST_ONE;
            end
          end
          default: state_q <= ST_EMPTY;
        endcase
      end
    end
  end

endmodule

// File: doc/pipe_mux_reg.md
PIPE_MUX_REG -- requirements
Module: pipe_mux_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width per input.
REQ-002 SHALL have parameter N_IN, default 4, number of selectable inputs (>=2).
REQ-003 SHALL have derived parameter SEL_W = max(1, clog2(N_IN)).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have clk  input  1  rising-edge clock.
REQ-006 SHALL have rst  input  1  synchronous active-high reset.
REQ-007 SHALL have in_data  input  N_IN*WIDTH  packed inputs; input k at bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have sel  input  SEL_W  binary input select, sampled with in_valid.
REQ-009 SHALL have in_valid  input  1  upstream offers a word.
REQ-010 SHALL have in_ready  output  1  block accepts a word this cycle.
REQ-011 SHALL have out_data  output  WIDTH  selected word, registered.
REQ-012 SHALL have out_valid  output  1  out_data holds a word.
REQ-013 SHALL have out_ready  input  1  downstream accepts out_data.
REQ-014 SHALL have flush  input  1  discard all buffered words (pipeline kill).
REQ-015 SHALL have sel_err  output  1  sticky flag: out-of-range sel accepted.

Function
REQ-016 SHALL define input transfer as in_valid & in_ready, output transfer as out_valid & out_ready, both on the rising edge.
REQ-017 SHALL capture in_data slice [sel] on input transfer; latency input transfer to out_valid = 1 cycle.
REQ-018 SHALL, when sel >= N_IN on an input transfer, capture all-zero data and set sel_err.
REQ-019 SHALL hold two registers: MAIN (drives out_data) and SKID, with states EMPTY, ONE, FULL.
REQ-020 SHALL drive out_valid = (state != EMPTY) and in_ready = (state != FULL), both decoded from state register only (no combinational path from out_ready).
REQ-021 EMPTY: input transfer -> ONE, word to MAIN.
REQ-022 ONE: input only -> FULL, word to SKID; output only -> EMPTY; both -> ONE, new word to MAIN.
REQ-023 FULL: output transfer -> ONE, SKID moves to MAIN; no input accepted.
REQ-024 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, on flush=1, go to EMPTY next cycle, dropping MAIN, SKID and any simultaneous input word; sel_err unaffected.
REQ-026 SHALL give flush priority over both transfers in the same cycle.
REQ-027 SHALL preserve word order; no word duplicated or lost absent flush.

Reset
REQ-028 SHALL on rst=1 set state EMPTY, out_valid=0, in_ready=1, out_data=0, SKID=0, sel_err=0; rst overrides flush and transfers, including mid-operation in FULL.

Structure
REQ-029 SHALL place state encoding (EMPTY/ONE/FULL) and default WIDTH/N_IN constants in shared package pipe_mux_pkg.
REQ-030 SHALL instantiate one combinational sub-module mux_n_1 (parameters WIDTH, N_IN) implementing REQ-018 select and range check.

Verification
REQ-031 Reset: assert rst 2 cycles while in_valid=1 -> out_valid=0, in_ready=1, out_data=32'h0, sel_err=0.
REQ-032 Select: WIDTH=32, N_IN=4, inputs 32'h0000FFF0/32'h0/32'hFFFFFFFF/32'h00F0F000, sel=0..3 one per cycle, out_ready=1 -> out_data sequence matches one cycle later, out_valid continuous.
REQ-033 Backpressure: out_ready=0, push 32'hA, 32'hB -> in_ready=0 after second; release out_ready -> 32'hA then 32'hB, in_ready returns 1 after first pop.
REQ-034 Flush in FULL with in_valid=1 (32'hC) -> next cycle out_valid=0, in_ready=1; 32'hC never appears.
REQ-035 Range: N_IN=3, sel=3 with data 32'h1234 -> out_data=32'h0, sel_err=1 held until rst.
REQ-036 Random: random in_valid/out_ready/sel, 10k cycles -> scoreboard order match, no handshake-stability violations.
